prog_delay_line: RTL and testbench

- Parametrised successor of the single-register `q <= #(REG_DELAY*2) d` style delay used across our test modules.
- Synthesizable WIDTH-bit delay line whose latency can be changed at run time, from 0 to DEPTH clock cycles.
- Each stage carries its own valid flag, so bubbles are delayed along with the data.
- Supports stall (en), synchronous flush (clear), out-of-range detection and an in-flight count.
- Sits between a producer and a consumer that need configurable, cycle-exact alignment (e.g. matching pipeline skews).

---
 rtl/prog_delay_line.sv | 91 +++++++++
 tb/tb_prog_delay_line.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line: DEPTH valid-tagged stages with a movable
// output tap (0 = combinational bypass), stall, flush and out-of-range flag.
module prog_delay_line #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned RESET_DLY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       clear,
    input  logic [$clog2(DEPTH+1)-1:0] dly,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic                       dly_err
);

    localparam int unsigned DLY_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s_data [DEPTH];
    logic [DEPTH-1:0] s_vld;
    logic [DLY_W-1:0] dly_q;
    logic             dly_over;
    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;
    logic [DLY_W-1:0] vld_cnt;

    assign dly_over = (dly > DLY_W'(DEPTH));

    // Data bits only move on enabled, non-flush edges; a flush leaves them in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                s_data[k] <= '0;
            end
        end else if (en && !clear) begin
            s_data[0] <= d;
            for (int k = 1; k < int'(DEPTH); k++) begin
                s_data[k] <= s_data[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_vld <= '0;
        end else if (clear) begin
            s_vld <= '0;
        end else if (en) begin
            s_vld[0] <= d_valid;
            for (int k = 1; k < int'(DEPTH); k++) begin
                s_vld[k] <= s_vld[k-1];
            end
        end
    end

    // Delay request is sampled every edge; a fresh out-of-range request wins over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_q   <= DLY_W'(RESET_DLY);
            dly_err <= 1'b0;
        end else begin
            dly_q   <= dly_over ? DLY_W'(DEPTH) : dly;
            dly_err <= dly_over | (dly_err & ~clear);
        end
    end

    // Tap select and popcount of the stages that make up the active delay.
    always_comb begin
        tap_data = '0;
        tap_vld  = 1'b0;
        vld_cnt  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (DLY_W'(k + 1) == dly_q) begin
                tap_data = s_data[k];
                tap_vld  = s_vld[k];
            end
            if (DLY_W'(k) < dly_q) begin
                vld_cnt = vld_cnt + DLY_W'(s_vld[k]);
            end
        end
    end

    assign q         = (dly_q == '0) ? d : tap_data;
    assign q_valid   = (dly_q == '0) ? (d_valid & ~clear) : tap_vld;
    assign in_flight = vld_cnt;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line (WIDTH=8, DEPTH=8, RESET_DLY=1):
// a vector table for steady streaming plus hand sequences for multi-cycle cases.
module tb_prog_delay_line;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clear;
    logic [3:0] dly;
    logic [7:0] d;
    logic       d_valid;
    logic [7:0] q;
    logic       q_valid;
    logic [3:0] in_flight;
    logic       dly_err;

    int checks;
    int failures;

    typedef struct {
        logic       en;
        logic       clear;
        logic [3:0] dly;
        logic [7:0] d;
        logic       dv;
        logic       chk_q;
        logic [7:0] q;
        logic       qv;
        logic [3:0] inf;
        logic       err;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    prog_delay_line #(.WIDTH(8), .DEPTH(8), .RESET_DLY(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .clear     (clear),
        .dly       (dly),
        .d         (d),
        .d_valid   (d_valid),
        .q         (q),
        .q_valid   (q_valid),
        .in_flight (in_flight),
        .dly_err   (dly_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic c, input logic [3:0] dl,
                                input logic [7:0] dd, input logic v, input logic cq,
                                input logic [7:0] eq, input logic eqv,
                                input logic [3:0] ei, input logic ee);
        vec_t r;
        r.en = e; r.clear = c; r.dly = dl; r.d = dd; r.dv = v;
        r.chk_q = cq; r.q = eq; r.qv = eqv; r.inf = ei; r.err = ee;
        return r;
    endfunction

    initial begin
        logic [3:0] inf2 [13];
        checks   = 0;
        failures = 0;
        inf2 = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};

        // Default tap: 0x11..0x1A each shows on q one cycle after it is pushed.
        for (int i = 0; i < 12; i++) begin
            if (i == 0)
                tbl[i] = mk(1, 0, 4'd1, 8'h11, 1, 1, 8'h00, 0, 4'd0, 0);
            else if (i < 10)
                tbl[i] = mk(1, 0, 4'd1, 8'(32'h11 + i), 1, 1, 8'(32'h10 + i), 1, 4'd1, 0);
            else if (i == 10)
                tbl[i] = mk(1, 0, 4'd1, 8'h00, 0, 1, 8'h1A, 1, 4'd1, 0);
            else
                tbl[i] = mk(1, 0, 4'd1, 8'h00, 0, 1, 8'h00, 0, 4'd0, 0);
        end
        // Flush and move to full depth.
        tbl[12] = mk(1, 1, 4'd8, 8'h00, 0, 1, 8'h00, 0, 4'd0, 0);
        // Full depth with a bubble: 1,0,1,1 emerges 8 cycles later.
        for (int j = 0; j < 13; j++) begin
            logic [7:0] dd;
            logic       v;
            logic       eqv;
            logic [7:0] eq;
            dd  = (j < 4) ? 8'(32'hA0 + j) : 8'h00;
            v   = (j < 4) && (j != 1);
            eqv = (j == 8) || (j == 10) || (j == 11);
            eq  = (j == 8) ? 8'hA0 : ((j == 10) ? 8'hA2 : 8'hA3);
            tbl[13 + j] = mk(1, 0, 4'd8, dd, v, eqv, eq, eqv, inf2[j], 0);
        end

        reset_n = 1'b0;
        en      = 1'b1;
        clear   = 1'b0;
        dly     = 4'd1;
        d       = 8'h00;
        d_valid = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_inf", 32'(in_flight), 32'h0);
        chk("rst_err", 32'(dly_err), 32'h0);
        #21 reset_n = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) begin
            en      = tbl[i].en;
            clear   = tbl[i].clear;
            dly     = tbl[i].dly;
            d       = tbl[i].d;
            d_valid = tbl[i].dv;
            #1;
            if (tbl[i].chk_q) chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_qv", i), 32'(q_valid), 32'(tbl[i].qv));
            chk($sformatf("tbl%0d_inf", i), 32'(in_flight), 32'(tbl[i].inf));
            chk($sformatf("tbl%0d_err", i), 32'(dly_err), 32'(tbl[i].err));
            step();
        end

        // Stall at dly=3: 0x55 needs exactly three enabled edges.
        en = 1; clear = 1; dly = 4'd3; d = 8'h00; d_valid = 0;
        step();
        clear = 0; d = 8'h55; d_valid = 1;
        step();
        d = 8'h66;
        step();
        chk("stall_pre_qv", 32'(q_valid), 32'h0);
        chk("stall_pre_inf", 32'(in_flight), 32'd2);
        en = 0; d = 8'h77; d_valid = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stall%0d_qv", c), 32'(q_valid), 32'h0);
            chk($sformatf("stall%0d_inf", c), 32'(in_flight), 32'd2);
            step();
        end
        en = 1; d = 8'h00; d_valid = 0;
        step();
        chk("stall_out_q", 32'(q), 32'h55);
        chk("stall_out_qv", 32'(q_valid), 32'h1);
        chk("stall_out_inf", 32'(in_flight), 32'd2);
        step();
        chk("stall_out2_q", 32'(q), 32'h66);
        chk("stall_out2_qv", 32'(q_valid), 32'h1);
        chk("stall_out2_inf", 32'(in_flight), 32'd1);

        // Bypass, clear masking, then switch to dly=2 exposing stage contents.
        dly = 4'd0; d = 8'h3C; d_valid = 1;
        step();
        chk("byp_q", 32'(q), 32'h3C);
        chk("byp_qv", 32'(q_valid), 32'h1);
        chk("byp_inf", 32'(in_flight), 32'h0);
        clear = 1;
        #1;
        chk("byp_clr_q", 32'(q), 32'h3C);
        chk("byp_clr_qv", 32'(q_valid), 32'h0);
        step();
        clear = 0; dly = 4'd2; d = 8'h4D; d_valid = 1;
        #1;
        chk("byp2_q", 32'(q), 32'h4D);
        chk("byp2_qv", 32'(q_valid), 32'h1);
        step();
        chk("sw_q", 32'(q), 32'h3C);
        chk("sw_qv", 32'(q_valid), 32'h0);
        chk("sw_inf", 32'(in_flight), 32'd1);
        d = 8'h00; d_valid = 0;
        step();
        chk("sw2_q", 32'(q), 32'h4D);
        chk("sw2_qv", 32'(q_valid), 32'h1);

        // Out-of-range request clamps to 8 and sets a sticky error.
        dly = 4'd12; d = 8'hB1; d_valid = 1;
        #1;
        chk("oor_pre_err", 32'(dly_err), 32'h0);
        step();
        d = 8'h00; d_valid = 0;
        #1;
        chk("oor_err", 32'(dly_err), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) chk("oor_k6_qv", 32'(q_valid), 32'h0);
        end
        chk("oor_q", 32'(q), 32'hB1);
        chk("oor_qv", 32'(q_valid), 32'h1);
        chk("oor_inf", 32'(in_flight), 32'd1);
        chk("oor_err2", 32'(dly_err), 32'h1);
        dly = 4'd4;
        step();
        chk("sticky_err", 32'(dly_err), 32'h1);
        chk("sticky_qv", 32'(q_valid), 32'h0);
        chk("sticky_inf", 32'(in_flight), 32'h0);
        d = 8'hC1; d_valid = 1;
        step();
        chk("preclr_inf", 32'(in_flight), 32'd1);
        clear = 1; d = 8'hC2;
        #1;
        chk("preclr_err", 32'(dly_err), 32'h1);
        step();
        clear = 0; d_valid = 0;
        #1;
        chk("clr_err", 32'(dly_err), 32'h0);
        chk("clr_qv", 32'(q_valid), 32'h0);
        chk("clr_inf", 32'(in_flight), 32'h0);

        // Async reset between edges with words in flight at dly=5.
        dly = 4'd5;
        for (int w = 0; w < 5; w++) begin
            d = 8'(32'hD1 + w); d_valid = 1;
            step();
        end
        d_valid = 0;
        #1;
        chk("ar_pre_q", 32'(q), 32'hD1);
        chk("ar_pre_qv", 32'(q_valid), 32'h1);
        chk("ar_pre_inf", 32'(in_flight), 32'd5);
        d = 8'hE1; d_valid = 1; dly = 4'd1;
        #1 reset_n = 1'b0;
        #1;
        chk("ar_qv", 32'(q_valid), 32'h0);
        chk("ar_inf", 32'(in_flight), 32'h0);
        chk("ar_q", 32'(q), 32'h0);
        #2 reset_n = 1'b1;
        step();
        chk("ar_post_q", 32'(q), 32'hE1);
        chk("ar_post_qv", 32'(q_valid), 32'h1);
        chk("ar_post_inf", 32'(in_flight), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
